// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision adder front end.
package fp_pkg;

  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned GUARD_W  = 8;
  localparam int unsigned MANT_W   = 32;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
    logic a_zero;
    logic b_zero;
  } fp_flags_t;

  // Classified and magnitude-ordered operands held between the two stages.
  typedef struct packed {
    fp32_t       a;
    fp32_t       b;
    fp_flags_t   flags;
    logic [23:0] big_mant;
    logic [23:0] small_mant;
    logic [7:0]  exp_big;
    logic [7:0]  diff;
    logic        eff_op;
    logic        sign_big;
  } s1_t;

endpackage

// File: rtl/fp_align_shift.sv
// Sticky right shifter: bits shifted off the bottom are ORed into bit 0.
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] i_mant,
  input  logic [7:0]        i_diff,
  output logic [MANT_W-1:0] o_mant
);

  logic [MANT_W-1:0] w_shifted;
  logic [MANT_W-1:0] w_lost_mask;
  logic              w_sticky;

  always_comb begin
    w_shifted   = i_mant >> i_diff[4:0];
    w_lost_mask = ~({MANT_W{1'b1}} << i_diff[4:0]);
    w_sticky    = |(i_mant & w_lost_mask);
    // Whole mantissa falls out of range: only its sticky survives.
    if (i_diff >= 8'(MANT_W)) begin
      o_mant = {{(MANT_W-1){1'b0}}, |i_mant};
    end else begin
      o_mant = w_shifted | {{(MANT_W-1){1'b0}}, w_sticky};
    end
  end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage FP add front end: classify/order operands, then align and add mantissas.
module fp_align_add
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned FRAC_W  = 23,
  parameter int unsigned GUARD_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 opA,
  input  logic [31:0]                 opB,
  input  logic                        sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 A,
  output logic [31:0]                 B,
  output logic                        signA,
  output logic                        signB,
  output logic                        ANaN,
  output logic                        BNaN,
  output logic                        Ainf,
  output logic                        Binf,
  output logic                        Azero,
  output logic                        Bzero,
  output logic                        alignedSign,
  output logic [FRAC_W+GUARD_W:0]     alignedResult,
  output logic                        carryOut,
  output logic [EXP_W-1:0]            exponentOut
);

  localparam int unsigned SUM_W = 1 + FRAC_W + GUARD_W;

  s1_t         r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;

  fp32_t       w_a;
  fp32_t       w_b;
  s1_t         w_s1_next;
  logic        w_s1_adv;
  logic        w_hid_a;
  logic        w_hid_b;
  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic        w_a_big;

  logic [MANT_W-1:0] w_big;
  logic [MANT_W-1:0] w_small;
  logic [MANT_W-1:0] w_aligned;
  logic [MANT_W:0]   w_sum;
  logic              w_zero_res;

  // Subtraction is folded in by flipping B's sign on entry.
  assign w_a = fp32_t'(opA);
  assign w_b = fp32_t'({opB[31] ^ sub, opB[30:0]});

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign out_valid = r_s2_valid;

  // Stage 1: classify both operands and order them by magnitude (tie keeps A as big).
  always_comb begin
    w_s1_next = '0;
    w_hid_a   = (w_a.exp != 8'd0);
    w_hid_b   = (w_b.exp != 8'd0);
    w_exp_a   = w_hid_a ? w_a.exp : 8'd1;
    w_exp_b   = w_hid_b ? w_b.exp : 8'd1;
    w_a_big   = {w_a.exp, w_a.frac} >= {w_b.exp, w_b.frac};

    w_s1_next.a = w_a;
    w_s1_next.b = w_b;
    w_s1_next.flags.a_nan  = (w_a.exp == EXP_MAX) && (w_a.frac != 23'd0);
    w_s1_next.flags.b_nan  = (w_b.exp == EXP_MAX) && (w_b.frac != 23'd0);
    w_s1_next.flags.a_inf  = (w_a.exp == EXP_MAX) && (w_a.frac == 23'd0);
    w_s1_next.flags.b_inf  = (w_b.exp == EXP_MAX) && (w_b.frac == 23'd0);
    w_s1_next.flags.a_zero = (w_a.exp == 8'd0) && (w_a.frac == 23'd0);
    w_s1_next.flags.b_zero = (w_b.exp == 8'd0) && (w_b.frac == 23'd0);
    w_s1_next.eff_op       = w_a.sign ^ w_b.sign;

    if (w_a_big) begin
      w_s1_next.big_mant   = {w_hid_a, w_a.frac};
      w_s1_next.small_mant = {w_hid_b, w_b.frac};
      w_s1_next.exp_big    = w_exp_a;
      w_s1_next.diff       = w_exp_a - w_exp_b;
      w_s1_next.sign_big   = w_a.sign;
    end else begin
      w_s1_next.big_mant   = {w_hid_b, w_b.frac};
      w_s1_next.small_mant = {w_hid_a, w_a.frac};
      w_s1_next.exp_big    = w_exp_b;
      w_s1_next.diff       = w_exp_b - w_exp_a;
      w_s1_next.sign_big   = w_b.sign;
    end
  end

  assign w_big   = {r_s1.big_mant, 8'd0};
  assign w_small = {r_s1.small_mant, 8'd0};

  fp_align_shift u_align_shift (
    .i_mant (w_small),
    .i_diff (r_s1.diff),
    .o_mant (w_aligned)
  );

  // Stage 2: add or subtract; big >= aligned so the difference never goes negative.
  always_comb begin
    w_sum = '0;
    if (r_s1.eff_op) begin
      w_sum = {1'b0, w_big - w_aligned};
    end else begin
      w_sum = {1'b0, w_big} + {1'b0, w_aligned};
    end
    w_zero_res = (|r_s1.flags) || (r_s1.eff_op && (w_sum == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s1          <= '0;
      A             <= '0;
      B             <= '0;
      signA         <= 1'b0;
      signB         <= 1'b0;
      ANaN          <= 1'b0;
      BNaN          <= 1'b0;
      Ainf          <= 1'b0;
      Binf          <= 1'b0;
      Azero         <= 1'b0;
      Bzero         <= 1'b0;
      alignedSign   <= 1'b0;
      alignedResult <= '0;
      carryOut      <= 1'b0;
      exponentOut   <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        r_s1 <= w_s1_next;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv && r_s1_valid) begin
        A     <= r_s1.a;
        B     <= r_s1.b;
        signA <= r_s1.a.sign;
        signB <= r_s1.b.sign;
        ANaN  <= r_s1.flags.a_nan;
        BNaN  <= r_s1.flags.b_nan;
        Ainf  <= r_s1.flags.a_inf;
        Binf  <= r_s1.flags.b_inf;
        Azero <= r_s1.flags.a_zero;
        Bzero <= r_s1.flags.b_zero;
        if (w_zero_res) begin
          alignedSign   <= 1'b0;
          alignedResult <= '0;
          carryOut      <= 1'b0;
          exponentOut   <= '0;
        end else begin
          alignedSign   <= r_s1.sign_big;
          alignedResult <= w_sum[SUM_W-1:0];
          carryOut      <= w_sum[SUM_W];
          exponentOut   <= EXP_W'(r_s1.exp_big);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: directed vectors, backpressure and mid-flight reset.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        signA;
  logic        signB;
  logic        ANaN;
  logic        BNaN;
  logic        Ainf;
  logic        Binf;
  logic        Azero;
  logic        Bzero;
  logic        alignedSign;
  logic [31:0] alignedResult;
  logic        carryOut;
  logic [7:0]  exponentOut;

  always #5 clk = ~clk;

  fp_align_add dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opA           (opA),
    .opB           (opB),
    .sub           (sub),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .A             (A),
    .B             (B),
    .signA         (signA),
    .signB         (signB),
    .ANaN          (ANaN),
    .BNaN          (BNaN),
    .Ainf          (Ainf),
    .Binf          (Binf),
    .Azero         (Azero),
    .Bzero         (Bzero),
    .alignedSign   (alignedSign),
    .alignedResult (alignedResult),
    .carryOut      (carryOut),
    .exponentOut   (exponentOut)
  );

  // Flags ordered {ANaN, BNaN, Ainf, Binf, Azero, Bzero}.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [5:0]  fl;
    logic        sg;
    logic [31:0] res;
    logic        cy;
    logic [7:0]  ex;
  } exp_t;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic        s;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  exp_t m_e;
  vec_t vecs[14];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] oa, input logic [31:0] ob, input logic s,
                               input logic [31:0] eb, input logic sa, input logic sb,
                               input logic [5:0] fl, input logic sg, input logic [31:0] res,
                               input logic cy, input logic [7:0] ex);
    vec_t v;
    v.opa    = oa;
    v.opb    = ob;
    v.s      = s;
    v.e.a    = oa;
    v.e.b    = eb;
    v.e.sa   = sa;
    v.e.sb   = sb;
    v.e.fl   = fl;
    v.e.sg   = sg;
    v.e.res  = res;
    v.e.cy   = cy;
    v.e.ex   = ex;
    return v;
  endfunction

  // Monitor: compare every accepted output against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got A=%h expected no output", A);
      end else begin
        m_e = exp_q.pop_front();
        chk("A", A, m_e.a);
        chk("B", B, m_e.b);
        chk("signs", {30'd0, signA, signB}, {30'd0, m_e.sa, m_e.sb});
        chk("flags", {26'd0, ANaN, BNaN, Ainf, Binf, Azero, Bzero}, {26'd0, m_e.fl});
        chk("alignedSign", {31'd0, alignedSign}, {31'd0, m_e.sg});
        chk("alignedResult", alignedResult, m_e.res);
        chk("carryOut", {31'd0, carryOut}, {31'd0, m_e.cy});
        chk("exponentOut", {24'd0, exponentOut}, {24'd0, m_e.ex});
      end
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    in_valid = 1'b1;
    opA      = v.opa;
    opB      = v.opb;
    sub      = v.s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
      exp_q.push_back(v.e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mkv(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h00000000, 1'b1, 8'h7F);
    vecs[1]  = mkv(32'h3F800000, 32'h30800000, 1'b0, 32'h30800000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80000002, 1'b0, 8'h7F);
    vecs[2]  = mkv(32'h3F800000, 32'h2B800000, 1'b0, 32'h2B800000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80000001, 1'b0, 8'h7F);
    vecs[3]  = mkv(32'h3F800000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b1, 6'b000000, 1'b0, 32'h00000000, 1'b0, 8'h00);
    vecs[4]  = mkv(32'h7F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b1, 6'b001100, 1'b0, 32'h00000000, 1'b0, 8'h00);
    vecs[5]  = mkv(32'h40000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b1, 6'b000000, 1'b0, 32'h40000000, 1'b0, 8'h80);
    vecs[6]  = mkv(32'h3F800000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 1'b1, 6'b000000, 1'b1, 32'h40000000, 1'b0, 8'h80);
    vecs[7]  = mkv(32'h7FC00000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 6'b100000, 1'b0, 32'h00000000, 1'b0, 8'h00);
    vecs[8]  = mkv(32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 6'b000010, 1'b0, 32'h00000000, 1'b0, 8'h00);
    vecs[9]  = mkv(32'h00400000, 32'h00400000, 1'b0, 32'h00400000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80000000, 1'b0, 8'h01);
    vecs[10] = mkv(32'h3F800000, 32'h30000000, 1'b0, 32'h30000000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80000001, 1'b0, 8'h7F);
    vecs[11] = mkv(32'h3F800000, 32'h2F800000, 1'b0, 32'h2F800000, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80000001, 1'b0, 8'h7F);
    vecs[12] = mkv(32'h3F800000, 32'h38000001, 1'b0, 32'h38000001, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h80010001, 1'b0, 8'h7F);
    vecs[13] = mkv(32'hBF800000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b1, 1'b1, 6'b000000, 1'b1, 32'h00000000, 1'b1, 8'h7F);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    opA       = 32'd0;
    opB       = 32'd0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", alignedResult, 32'd0);
    chk("rst_exponent", {24'd0, exponentOut}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First result must appear two cycles after the accepting cycle.
    send(vecs[0]);
    @(negedge clk);
    chk("latency_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_cycle2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    for (int i = 1; i < 14; i++) begin
      send(vecs[i]);
    end
    wait_drain();

    // Backpressure: two accepted, third blocked, outputs frozen on the oldest.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    fork
      send(vecs[5]);
      begin
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
          chk("stall_result_hold", alignedResult, 32'h80000002);
          chk("stall_B_hold", B, 32'h30800000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with both stages full discards the in-flight work.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[6]);
    @(negedge clk);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_result", alignedResult, 32'd0);
    chk("flush_carry", {31'd0, carryOut}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(vecs[12]);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
